// File: rtl/dpe_pkg.sv
// dpe_pkg: shared DPE types and defaults
package dpe_pkg;

  localparam int DPE_CNT_WIDTH = 8;

  typedef enum logic [2:0] {
    RUN,
    PAUSE_WAIT,
    DRAIN,
    HOLD,
    RESUME,
    ABORT
  } pause_state_t;

endpackage

// File: rtl/dpe_inflight_cnt.sv
// dpe_inflight_cnt: saturating packet counter with sticky over/underflow flag
module dpe_inflight_cnt
  import dpe_pkg::*;
#(
  parameter int WIDTH = DPE_CNT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt,
  output logic             err
);

  logic up;
  logic dn;
  logic ovf;
  logic udf;

  assign up  = inc & ~dec;
  assign dn  = dec & ~inc;
  assign ovf = up & (cnt == '1);
  assign udf = dn & (cnt == '0);

  // count packet boundaries, holding at the rails on a fault
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (up & ~ovf) cnt <= cnt + WIDTH'(1);
    else if (dn & ~udf) cnt <= cnt - WIDTH'(1);

  // sticky fault flag; a new fault beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err <= 1'b0;
    else err <= ovf | udf | (err & ~clr);

endmodule

// File: rtl/dpe_pause_ctrl.sv
// dpe_pause_ctrl: sequences the ingress mux pause/paused handshake for CPU table updates
module dpe_pause_ctrl
  import dpe_pkg::*;
#(
  parameter int CNT_WIDTH      = DPE_CNT_WIDTH,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_pause_req,
  output logic                 cpu_pause_ack,
  output logic                 mux_pause,
  input  logic                 mux_paused,
  input  logic                 ing_tvalid,
  input  logic                 ing_tready,
  input  logic                 ing_tlast,
  input  logic                 egr_tvalid,
  input  logic                 egr_tready,
  input  logic                 egr_tlast,
  output logic [CNT_WIDTH-1:0] inflight,
  input  logic                 err_clr,
  output logic                 timeout_err,
  output logic                 count_err
);

  localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

  pause_state_t  state;
  logic [TW-1:0] tcnt;
  logic          ing_evt;
  logic          egr_evt;
  logic          waiting;
  logic          timeout;
  logic          drained;
  logic          progress;
  logic          abort_evt;

  assign ing_evt   = ing_tvalid & ing_tready & ing_tlast;
  assign egr_evt   = egr_tvalid & egr_tready & egr_tlast;
  assign waiting   = (state == PAUSE_WAIT) | (state == DRAIN);
  assign timeout   = (TIMEOUT_CYCLES != 0) & (tcnt == TLIM);
  assign drained   = mux_paused & (inflight == '0) & ~ing_evt & ~egr_evt;
  assign progress  = (state == PAUSE_WAIT) ? mux_paused : drained;
  assign abort_evt = waiting & cpu_pause_req & ~progress & timeout;

  dpe_inflight_cnt #(
    .WIDTH(CNT_WIDTH)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (ing_evt),
    .dec  (egr_evt),
    .clr  (err_clr),
    .cnt  (inflight),
    .err  (count_err)
  );

  // quiesce timer: zero outside the wait states, saturating count inside
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tcnt <= '0;
    else tcnt <= !waiting ? '0 : (tcnt == TLIM) ? tcnt : tcnt + TW'(1);

  // pause sequencer; outputs are registered to match the state being entered
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= RUN;
      mux_pause     <= 1'b0;
      cpu_pause_ack <= 1'b0;
    end else begin
      case (state)
        RUN:
          if (cpu_pause_req) begin
            state     <= PAUSE_WAIT;
            mux_pause <= 1'b1;
          end
        PAUSE_WAIT, DRAIN:
          if (!cpu_pause_req) begin
            state     <= RESUME;
            mux_pause <= 1'b0;
          end else if (progress) begin
            state         <= (state == PAUSE_WAIT) ? DRAIN : HOLD;
            cpu_pause_ack <= state == DRAIN;
          end else if (timeout) begin
            state     <= ABORT;
            mux_pause <= 1'b0;
          end
        HOLD:
          if (!cpu_pause_req) begin
            state         <= RESUME;
            mux_pause     <= 1'b0;
            cpu_pause_ack <= 1'b0;
          end
        RESUME: state <= RUN;
        ABORT:  if (!cpu_pause_req) state <= RUN;
        default: begin
          state         <= RUN;
          mux_pause     <= 1'b0;
          cpu_pause_ack <= 1'b0;
        end
      endcase
    end

  // sticky abort flag; a new abort beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) timeout_err <= 1'b0;
    else timeout_err <= abort_evt | (timeout_err & ~err_clr);

endmodule

// File: tb/tb_dpe_pause_ctrl.sv
// tb_dpe_pause_ctrl: directed scoreboard bench for the pause sequencer
module tb_dpe_pause_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic       paused = 1'b0;
  logic       iv = 1'b0, ir = 1'b0, il = 1'b0;
  logic       ev = 1'b0, er = 1'b0, el = 1'b0;
  logic       clr = 1'b0;
  logic       ack, mp, terr, cerr;
  logic [7:0] inf;
  logic       s_ack, s_mp, s_terr, s_cerr;
  logic [1:0] s_inf;
  logic [14:0] obs;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [14:0] exp;
    logic [14:0] mask;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  assign obs = {s_cerr, s_inf, mp, ack, terr, cerr, inf};

  dpe_pause_ctrl #(.CNT_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_pause_req(req), .cpu_pause_ack(ack),
    .mux_pause(mp), .mux_paused(paused),
    .ing_tvalid(iv), .ing_tready(ir), .ing_tlast(il),
    .egr_tvalid(ev), .egr_tready(er), .egr_tlast(el),
    .inflight(inf), .err_clr(clr), .timeout_err(terr), .count_err(cerr)
  );

  dpe_pause_ctrl #(.CNT_WIDTH(2), .TIMEOUT_CYCLES(16)) dut_s (
    .clk(clk), .rst_n(rst_n), .cpu_pause_req(req), .cpu_pause_ack(s_ack),
    .mux_pause(s_mp), .mux_paused(paused),
    .ing_tvalid(iv), .ing_tready(ir), .ing_tlast(il),
    .egr_tvalid(ev), .egr_tready(er), .egr_tlast(el),
    .inflight(s_inf), .err_clr(clr), .timeout_err(s_terr), .count_err(s_cerr)
  );

  task automatic push(input string tag, input logic p, input logic a, input logic te,
                      input logic ce, input logic [7:0] n);
    sb.push_back('{tag, {3'b000, p, a, te, ce, n}, 15'h0fff});
  endtask

  task automatic push_s(input string tag, input logic ce, input logic [1:0] n);
    sb.push_back('{tag, {ce, n, 12'h000}, 15'h7000});
  endtask

  task automatic check_now();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert ((obs & e.mask) === (e.exp & e.mask)) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs & e.mask, e.exp & e.mask);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_now();
  endtask

  task automatic set_ing(input logic b);
    iv = b; ir = b; il = b;
  endtask

  task automatic set_egr(input logic b);
    ev = b; er = b; el = b;
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1 push("reset", 0, 0, 0, 0, 0);
    push_s("reset_s", 0, 0);
    check_now();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int n;
    bit hold;
    #12;
    push("por", 0, 0, 0, 0, 0);
    push_s("por_s", 0, 0);
    check_now();
    rst_n = 1'b1;
    tick();

    req = 1'b1;
    push("idle_mp_rise", 1, 0, 0, 0, 0);
    tick();
    repeat (3) begin
      push("idle_pw", 1, 0, 0, 0, 0);
      tick();
    end
    paused = 1'b1;
    push("idle_drain", 1, 0, 0, 0, 0);
    tick();
    push("idle_ack", 1, 1, 0, 0, 0);
    tick();
    push("idle_hold", 1, 1, 0, 0, 0);
    tick();
    req = 1'b0;
    push("idle_release", 0, 0, 0, 0, 0);
    tick();
    paused = 1'b0;
    push("idle_run", 0, 0, 0, 0, 0);
    tick();

    set_ing(1'b1);
    for (int i = 1; i <= 3; i++) begin
      push("drain_ing", 0, 0, 0, 0, 8'(i));
      tick();
    end
    set_ing(1'b0);
    req = 1'b1;
    paused = 1'b1;
    push("drain_mp", 1, 0, 0, 0, 3);
    tick();
    n = 3;
    hold = 1'b0;
    for (int c = 2; c <= 14; c++) begin
      set_egr(c == 5 || c == 9 || c == 12);
      if (!hold && c > 2 && n == 0 && !ev) hold = 1'b1;
      if (ev) n--;
      push("drain_step", 1, hold, 0, 0, 8'(n));
      push_s("drain_step_s", 0, 2'(n));
      tick();
    end
    set_egr(1'b0);
    req = 1'b0;
    push("drain_release", 0, 0, 0, 0, 0);
    tick();
    paused = 1'b0;
    tick();

    req = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      push("timeout_seq", c <= 16, 0, c == 17, 0, 0);
      tick();
    end
    repeat (2) begin
      push("abort_hold", 0, 0, 1, 0, 0);
      tick();
    end
    clr = 1'b1;
    push("abort_clr", 0, 0, 0, 0, 0);
    tick();
    clr = 1'b0;
    repeat (3) begin
      push("abort_no_retry", 0, 0, 0, 0, 0);
      tick();
    end
    req = 1'b0;
    push("abort_exit", 0, 0, 0, 0, 0);
    tick();
    req = 1'b1;
    push("abort_left", 1, 0, 0, 0, 0);
    tick();
    req = 1'b0;
    push("abort_left_resume", 0, 0, 0, 0, 0);
    tick();
    tick();

    req = 1'b1;
    push("cancel_pw1", 1, 0, 0, 0, 0);
    tick();
    push("cancel_pw2", 1, 0, 0, 0, 0);
    tick();
    req = 1'b0;
    push("cancel_resume", 0, 0, 0, 0, 0);
    tick();
    push("cancel_run", 0, 0, 0, 0, 0);
    tick();

    set_ing(1'b1);
    for (int i = 1; i <= 5; i++) begin
      push("cnt_up", 0, 0, 0, 0, 8'(i));
      push_s("cnt_sat_s", i >= 4, 2'(i > 3 ? 3 : i));
      tick();
    end
    set_egr(1'b1);
    push("cnt_both", 0, 0, 0, 0, 5);
    tick();
    set_ing(1'b0);
    set_egr(1'b0);
    do_reset();
    set_egr(1'b1);
    push("cnt_underflow", 0, 0, 0, 1, 0);
    tick();
    set_egr(1'b0);
    clr = 1'b1;
    push("cnt_clr", 0, 0, 0, 0, 0);
    tick();
    set_egr(1'b1);
    push("cnt_set_wins", 0, 0, 0, 1, 0);
    tick();
    set_egr(1'b0);
    clr = 1'b0;
    do_reset();

    req = 1'b1;
    paused = 1'b1;
    push("rst_pw", 1, 0, 0, 0, 0);
    tick();
    push("rst_drain", 1, 0, 0, 0, 0);
    tick();
    push("rst_hold", 1, 1, 0, 0, 0);
    tick();
    set_ing(1'b1);
    push("rst_hold_ing1", 1, 1, 0, 0, 1);
    tick();
    push("rst_hold_ing2", 1, 1, 0, 0, 2);
    tick();
    set_ing(1'b0);
    do_reset();
    push("rst_run_pw", 1, 0, 0, 0, 0);
    tick();
    push("rst_run_drain", 1, 0, 0, 0, 0);
    tick();
    push("rst_run_hold", 1, 1, 0, 0, 0);
    tick();
    req = 1'b0;
    paused = 1'b0;
    push("rst_run_release", 0, 0, 0, 0, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
